mem_wb_skid_stage: RTL

Parametrised memory-to-writeback pipeline register with a valid/ready handshake and a two-entry skid buffer. It replaces the free-running MEM→WB register, so the writeback stage can stall without losing data and without a combinational ready path back into memory. It supports a synchronous flush that turns in-flight entries into bubbles, and it keeps a saturating stall counter for performance debug.

---
 rtl/mem_wb_skid_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with valid/ready handshake.
// Two-entry skid keeps in_ready registered; flush kills held entries.

`ifndef WIDTH
`define WIDTH 32
`endif

module mem_wb_skid_stage #(
   parameter int                 INSTR_W   = `WIDTH,
   parameter int                 PC_W      = `WIDTH-2,
   parameter int                 DATA_W    = `WIDTH,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
   parameter int                 STALL_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instruction_in,
   input  logic [PC_W-1:0]    progcounter_in,
   input  logic [DATA_W-1:0]  dataC_in,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] instruction_out,
   output logic [PC_W-1:0]    progcounter_out,
   output logic [DATA_W-1:0]  dataC_out,
   output logic [STALL_W-1:0] stall_count
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic               rdy_q;
   logic [INSTR_W-1:0] main_instr;
   logic [PC_W-1:0]    main_pc;
   logic [DATA_W-1:0]  main_data;
   logic [INSTR_W-1:0] skid_instr;
   logic [PC_W-1:0]    skid_pc;
   logic [DATA_W-1:0]  skid_data;
   logic [STALL_W-1:0] stall_q;

   logic in_fire;
   logic out_fire;
   logic ld_main_in;
   logic ld_main_skid;
   logic ld_skid;

   assign out_valid       = (state != EMPTY);
   assign in_ready        = rdy_q;
   assign instruction_out = main_instr;
   assign progcounter_out = main_pc;
   assign dataC_out       = main_data;
   assign stall_count     = stall_q;

   assign in_fire  = in_valid & rdy_q;
   assign out_fire = out_valid & out_ready;

   assign ld_main_in   = !flush && in_fire &&
                         ((state == EMPTY) ||
                          ((state == ONE) && out_fire));
   assign ld_main_skid = !flush && (state == FULL) && out_fire;
   assign ld_skid      = !flush && (state == ONE) &&
                         in_fire && !out_fire;

   // Occupancy transitions; flush overrides everything.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (in_fire) state_nxt = ONE;
            ONE: begin
               if (in_fire && !out_fire)
                  state_nxt = FULL;
               else if (!in_fire && out_fire)
                  state_nxt = EMPTY;
            end
            FULL: if (out_fire) state_nxt = ONE;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // State register; ready is precomputed so it is a plain flop output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         rdy_q <= 1'b1;
      end else begin
         state <= state_nxt;
         rdy_q <= (state_nxt != FULL);
      end
   end

   // Head entry: NOP when empty, else newest input or promoted skid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_instr <= NOP_INSTR;
         main_pc    <= '0;
         main_data  <= '0;
      end else begin
         if (state_nxt == EMPTY)
            main_instr <= NOP_INSTR;
         else if (ld_main_in)
            main_instr <= instruction_in;
         else if (ld_main_skid)
            main_instr <= skid_instr;
         if (ld_main_in) begin
            main_pc   <= progcounter_in;
            main_data <= dataC_in;
         end else if (ld_main_skid) begin
            main_pc   <= skid_pc;
            main_data <= skid_data;
         end
      end
   end

   // Skid catches the entry that arrives while the head is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_instr <= '0;
         skid_pc    <= '0;
         skid_data  <= '0;
      end else if (ld_skid) begin
         skid_instr <= instruction_in;
         skid_pc    <= progcounter_in;
         skid_data  <= dataC_in;
      end
   end

   // Saturating count of stalled-output cycles; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_q <= '0;
      else if (out_valid && !out_ready && (stall_q != '1))
         stall_q <= stall_q + 1'b1;
   end

endmodule
